edf_irq_dispatch: RTL and testbench

- Sits directly downstream of the EDF interrupt controller.
- Consumes the arbitration winner (id plus relative deadline) through a valid/ready handshake and presents it to the core as a single outstanding interrupt.
- Tracks claim and complete from the core, and timestamps the absolute deadline against mtime.
- Flags and counts deadline misses so software can audit EDF schedulability.

---
 rtl/edf_irq_dispatch_if.sv | 29 ++
 rtl/edf_irq_dispatch.sv | 128 ++++++++++++
 tb/tb_edf_irq_dispatch.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edf_irq_dispatch_if.sv
// Upstream handshake between the EDF interrupt controller and the dispatcher.
// Member names are written from the dispatcher's point of view.
interface edf_irq_dispatch_if #(
    parameter int NrIrqs  = 4,
    parameter int TsWidth = 24
);
    localparam int IdWidth = (NrIrqs > 1) ? $clog2(NrIrqs) : 1;

    logic               irq_valid_i;
    logic [IdWidth-1:0] irq_id_i;
    logic [TsWidth-1:0] irq_dl_i;
    logic               irq_ready_o;

    // Controller side: offers the arbitration winner
    modport master (
        output irq_valid_i,
        output irq_id_i,
        output irq_dl_i,
        input  irq_ready_o
    );

    // Dispatcher side: accepts the arbitration winner
    modport slave (
        input  irq_valid_i,
        input  irq_id_i,
        input  irq_dl_i,
        output irq_ready_o
    );
endinterface

// File: rtl/edf_irq_dispatch.sv
// EDF interrupt dispatcher: takes one arbitration winner at a time, presents
// it to the core, tracks claim/complete and audits the absolute deadline
// against mtime, flagging and counting misses.
module edf_irq_dispatch #(
    parameter int NrIrqs       = 4,
    parameter int TsWidth      = 24,
    parameter int MissCntWidth = 8,
    localparam int IdWidth     = (NrIrqs > 1) ? $clog2(NrIrqs) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    edf_irq_dispatch_if.slave       up_if,
    input  logic [63:0]             mtime_i,
    output logic                    core_irq_o,
    output logic [IdWidth-1:0]      core_id_o,
    input  logic                    core_claim_i,
    input  logic                    core_complete_i,
    input  logic [IdWidth-1:0]      core_complete_id_i,
    output logic                    busy_o,
    output logic                    cpl_err_o,
    output logic                    dl_miss_o,
    output logic [IdWidth-1:0]      miss_id_o,
    output logic [MissCntWidth-1:0] miss_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;

    logic [1:0]              state_q,     state_d;
    logic [IdWidth-1:0]      id_q,        id_d;
    logic [63:0]             abs_dl_q,    abs_dl_d;
    logic                    miss_flag_q, miss_flag_d;
    logic                    cpl_err_q,   cpl_err_d;
    logic                    dl_miss_q,   dl_miss_d;
    logic [IdWidth-1:0]      miss_id_q,   miss_id_d;
    logic [MissCntWidth-1:0] miss_cnt_q,  miss_cnt_d;

    logic cpl_ok;
    logic in_service;
    logic late;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [MissCntWidth-1:0] sat_inc(input logic [MissCntWidth-1:0] v);
        if (&v) return v;
        return v + {{(MissCntWidth-1){1'b0}}, 1'b1};
    endfunction

    // Handshake and core-facing flags come only from registered state
    assign up_if.irq_ready_o = (state_q == ST_IDLE);
    assign core_irq_o        = (state_q == ST_PEND);
    assign busy_o            = (state_q != ST_IDLE);
    assign core_id_o         = id_q;
    assign cpl_err_o         = cpl_err_q;
    assign dl_miss_o         = dl_miss_q;
    assign miss_id_o         = miss_id_q;
    assign miss_cnt_o        = miss_cnt_q;

    // Only a matching complete while serving is legal; equality with abs_dl is still on time
    assign cpl_ok     = (state_q == ST_SERVE) && core_complete_i && (core_complete_id_i == id_q);
    assign in_service = (state_q == ST_PEND) || (state_q == ST_SERVE);
    assign late       = (mtime_i > abs_dl_q);

    // Next-state: FSM transitions, completion error pulse and one-shot miss accounting
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        abs_dl_d    = abs_dl_q;
        miss_flag_d = miss_flag_q;
        cpl_err_d   = 1'b0;
        dl_miss_d   = 1'b0;
        miss_id_d   = miss_id_q;
        miss_cnt_d  = miss_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (up_if.irq_valid_i) begin
                    state_d     = ST_PEND;
                    id_d        = up_if.irq_id_i;
                    abs_dl_d    = mtime_i + 64'(up_if.irq_dl_i);
                    miss_flag_d = 1'b0;
                end
            end
            ST_PEND: begin
                if (core_claim_i) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (cpl_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A complete in PEND (even alongside a claim) or with a stale id is an error
        if (core_complete_i && !cpl_ok) cpl_err_d = 1'b1;

        // First late cycle of this interrupt is reported; later ones are suppressed by miss_flag
        if (in_service && !miss_flag_q && late) begin
            miss_flag_d = 1'b1;
            dl_miss_d   = 1'b1;
            miss_id_d   = id_q;
            miss_cnt_d  = sat_inc(miss_cnt_q);
        end
    end

    // State register; reset abandons any outstanding interrupt without pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            abs_dl_q    <= '0;
            miss_flag_q <= 1'b0;
            cpl_err_q   <= 1'b0;
            dl_miss_q   <= 1'b0;
            miss_id_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            abs_dl_q    <= abs_dl_d;
            miss_flag_q <= miss_flag_d;
            cpl_err_q   <= cpl_err_d;
            dl_miss_q   <= dl_miss_d;
            miss_id_q   <= miss_id_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_edf_irq_dispatch.sv
// Directed bench for edf_irq_dispatch: basic flow, deadline miss and its
// boundary, completion errors, counter saturation and async reset.
module tb_edf_irq_dispatch;
    localparam int NrIrqs = 4;
    localparam int TsW    = 24;
    localparam int McW    = 8;
    localparam int IdW    = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [63:0]    mtime = '0;
    logic           core_irq;
    logic [IdW-1:0] core_id;
    logic           claim = 1'b0;
    logic           complete = 1'b0;
    logic [IdW-1:0] complete_id = '0;
    logic           busy;
    logic           cpl_err;
    logic           dl_miss;
    logic [IdW-1:0] miss_id;
    logic [McW-1:0] miss_cnt;

    int total = 0;
    int bad   = 0;
    int miss_pulses = 0;
    int pulses_ref;
    int exp_cnt;

    edf_irq_dispatch_if #(.NrIrqs(NrIrqs), .TsWidth(TsW)) up ();

    edf_irq_dispatch #(.NrIrqs(NrIrqs), .TsWidth(TsW), .MissCntWidth(McW)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .up_if              (up.slave),
        .mtime_i            (mtime),
        .core_irq_o         (core_irq),
        .core_id_o          (core_id),
        .core_claim_i       (claim),
        .core_complete_i    (complete),
        .core_complete_id_i (complete_id),
        .busy_o             (busy),
        .cpl_err_o          (cpl_err),
        .dl_miss_o          (dl_miss),
        .miss_id_o          (miss_id),
        .miss_cnt_o         (miss_cnt)
    );

    always #5 clk = ~clk;

    // Count every dl_miss_o pulse, sampled mid-cycle
    always @(negedge clk) if (dl_miss === 1'b1) miss_pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [IdW-1:0] id, input logic [TsW-1:0] dl, input logic [63:0] t);
        up.irq_valid_i = 1'b1;
        up.irq_id_i    = id;
        up.irq_dl_i    = dl;
        mtime          = t;
        step();
        up.irq_valid_i = 1'b0;
    endtask

    task automatic do_claim(input logic [63:0] t);
        mtime = t;
        claim = 1'b1;
        step();
        claim = 1'b0;
    endtask

    task automatic do_complete(input logic [IdW-1:0] id, input logic [63:0] t);
        mtime       = t;
        complete    = 1'b1;
        complete_id = id;
        step();
        complete    = 1'b0;
    endtask

    initial begin
        up.irq_valid_i = 1'b0;
        up.irq_id_i    = '0;
        up.irq_dl_i    = '0;
        step();
        step();
        // Reset values
        chk("rst_ready", up.irq_ready_o, 1);
        chk("rst_core_irq", core_irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_id", core_id, 0);
        chk("rst_cpl_err", cpl_err, 0);
        chk("rst_dl_miss", dl_miss, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        step();

        // Basic flow: id 2, dl 100 at mtime 1000 -> abs 1100
        accept(2'd2, 24'd100, 64'd1000);
        chk("basic_core_irq", core_irq, 1);
        chk("basic_core_id", core_id, 2);
        chk("basic_ready", up.irq_ready_o, 0);
        chk("basic_busy", busy, 1);
        do_claim(64'd1010);
        chk("basic_claim_irq", core_irq, 0);
        chk("basic_claim_busy", busy, 1);
        chk("basic_claim_id", core_id, 2);
        do_complete(2'd2, 64'd1050);
        chk("basic_done_ready", up.irq_ready_o, 1);
        chk("basic_done_busy", busy, 0);
        chk("basic_no_err", cpl_err, 0);
        chk("basic_no_miss", miss_pulses, 0);

        // Claim in IDLE is ignored
        do_claim(64'd1060);
        chk("idle_claim_ready", up.irq_ready_o, 1);
        chk("idle_claim_irq", core_irq, 0);
        chk("idle_claim_busy", busy, 0);
        chk("idle_claim_err", cpl_err, 0);

        // Deadline miss: id 1, dl 10 at 500 -> abs 510, first late at 511
        accept(2'd1, 24'd10, 64'd500);
        do_claim(64'd500);
        pulses_ref = miss_pulses;
        for (int m = 501; m <= 600; m++) begin
            mtime = 64'(m);
            step();
            if (m == 510) chk("miss_at_510", dl_miss, 0);
            if (m == 511) chk("miss_at_511", dl_miss, 1);
            if (m == 512) chk("miss_at_512", dl_miss, 0);
        end
        chk("miss_once", miss_pulses - pulses_ref, 1);
        chk("miss_id", miss_id, 1);
        chk("miss_cnt1", miss_cnt, 1);
        chk("miss_still_serve", busy, 1);
        do_complete(2'd1, 64'd601);
        chk("miss_done_ready", up.irq_ready_o, 1);
        chk("miss_done_err", cpl_err, 0);

        // Boundary: complete exactly at abs_dl is on time
        accept(2'd3, 24'd10, 64'd500);
        do_claim(64'd505);
        pulses_ref = miss_pulses;
        do_complete(2'd3, 64'd510);
        chk("bnd_eq_miss", dl_miss, 0);
        chk("bnd_eq_ready", up.irq_ready_o, 1);
        step();
        chk("bnd_eq_pulses", miss_pulses - pulses_ref, 0);
        chk("bnd_eq_cnt", miss_cnt, 1);

        // Boundary: complete in the detection cycle still reports the miss
        accept(2'd2, 24'd10, 64'd500);
        do_claim(64'd505);
        do_complete(2'd2, 64'd511);
        chk("bnd_late_miss", dl_miss, 1);
        chk("bnd_late_id", miss_id, 2);
        chk("bnd_late_cnt", miss_cnt, 2);
        chk("bnd_late_ready", up.irq_ready_o, 1);
        chk("bnd_late_busy", busy, 0);

        // Wrong-id complete while serving id 0
        accept(2'd0, 24'd1000, 64'd0);
        do_claim(64'd0);
        do_complete(2'd3, 64'd1);
        chk("err_wrong_id", cpl_err, 1);
        chk("err_wrong_busy", busy, 1);
        chk("err_wrong_ready", up.irq_ready_o, 0);
        chk("err_wrong_irq", core_irq, 0);
        step();
        chk("err_pulse_len", cpl_err, 0);
        do_complete(2'd0, 64'd2);
        chk("err_recover_ready", up.irq_ready_o, 1);
        chk("err_recover_err", cpl_err, 0);

        // Complete while IDLE
        do_complete(2'd0, 64'd3);
        chk("err_idle_cpl", cpl_err, 1);
        chk("err_idle_ready", up.irq_ready_o, 1);

        // Claim and complete together in PEND
        accept(2'd1, 24'd1000, 64'd10);
        claim = 1'b1;
        do_complete(2'd1, 64'd11);
        claim = 1'b0;
        chk("cc_err", cpl_err, 1);
        chk("cc_irq", core_irq, 0);
        chk("cc_busy", busy, 1);
        chk("cc_ready", up.irq_ready_o, 0);
        do_complete(2'd1, 64'd12);
        chk("cc_done_ready", up.irq_ready_o, 1);

        // Saturation: 260 more misses, each detected in PEND (dl=0, late next cycle)
        exp_cnt    = 2;
        pulses_ref = miss_pulses;
        for (int i = 0; i < 260; i++) begin
            accept(2'(i), 24'd0, 64'(1000 + 4 * i));
            do_claim(64'(1001 + 4 * i));
            do_complete(2'(i), 64'(1002 + 4 * i));
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (i == 252 || i == 253 || i == 259) chk("sat_cnt", miss_cnt, 64'(exp_cnt));
        end
        chk("sat_final", miss_cnt, 255);
        chk("sat_pulses", miss_pulses - pulses_ref, 260);
        chk("sat_last_id", miss_id, 3);

        // Async reset mid-SERVE
        accept(2'd3, 24'd1000, 64'd5000);
        do_claim(64'd5001);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", up.irq_ready_o, 1);
        chk("arst_busy", busy, 0);
        chk("arst_irq", core_irq, 0);
        chk("arst_id", core_id, 0);
        chk("arst_cnt", miss_cnt, 0);
        chk("arst_miss_id", miss_id, 0);
        chk("arst_err", cpl_err, 0);
        step();
        rst = 1'b0;
        step();
        accept(2'd2, 24'd50, 64'd0);
        chk("post_rst_irq", core_irq, 1);
        chk("post_rst_id", core_id, 2);
        do_claim(64'd1);
        do_complete(2'd2, 64'd2);
        chk("post_rst_ready", up.irq_ready_o, 1);
        chk("post_rst_cnt", miss_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
